// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
package mem_arb_types;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    // Index of a requesting port (0 = core, 1 = loader/debug)
    typedef logic arb_port_t;

    localparam int ARB_NPORTS = 2;

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory macro.
// slave  : arbiter view (consumes requests and read data, drives grants and memory controls)
// master : requester/memory view
interface rv32_mem_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;

    logic [31:0]       rdata;
    logic              busy;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_wr_ena;
    logic [31:0]       mem_rd_data;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rd_data,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        output rdata, busy, mem_addr, mem_wr_data, mem_wr_ena
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rd_data,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        input  rdata, busy, mem_addr, mem_wr_data, mem_wr_ena
    );
endinterface

// File: rtl/rv32_mem_arbiter_pick.sv
// Combinational winner selection for the two-port memory arbiter.
// ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go to the port not
// granted last; otherwise port 0 has priority unless the starvation guard fires.
module mem_arb_pick
    import mem_arb_types::*;
(
    input  logic [ARB_NPORTS-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
    input  arb_port_t             last_gnt,
`else
    input  logic                  hold_max,
`endif
    output arb_port_t             winner,
    output logic                  grant_valid
);

    // Pick one requester from the current request vector
    always_comb begin
        winner      = 1'b0;
        grant_valid = 1'b0;
        case (req)
            2'b00: begin
                winner      = 1'b0;
                grant_valid = 1'b0;
            end
            2'b01: begin
                winner      = 1'b0;
                grant_valid = 1'b1;
            end
            2'b10: begin
                winner      = 1'b1;
                grant_valid = 1'b1;
            end
            2'b11: begin
`ifdef ARB_ROUND_ROBIN_EN
                winner      = ~last_gnt;
`else
                winner      = hold_max;
`endif
                grant_valid = 1'b1;
            end
            default: begin
                winner      = 1'b0;
                grant_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Two-port arbiter sharing one synchronous-read memory between the core
// (port 0) and a loader/debug master (port 1). Writes finish in the grant
// cycle; a read holds the arbiter until its data returns.
// ARB_ROUND_ROBIN_EN: alternate on contention instead of port-0 priority with
// the MAX_HOLD starvation guard.
module rv32_mem_arbiter
    import mem_arb_types::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_HOLD     = 4,
    parameter int ADDR_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    rv32_mem_arbiter_if.slave  bus
);

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    arb_port_t         owner_r;
    logic [1:0]        lat_cnt_r;
    logic [ADDR_W-1:0] rd_addr_r;

    logic [ARB_NPORTS-1:0] req_vec_s;
    arb_port_t         pick_winner_s;
    logic              pick_valid_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic              sel_we_s;

    logic              gnt0_s;
    logic              gnt1_s;
    logic              rvalid0_s;
    logic              rvalid1_s;
    logic              busy_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_wr_data_s;
    logic              mem_wr_ena_s;

    assign req_vec_s = {bus.m1_req, bus.m0_req};

`ifdef ARB_ROUND_ROBIN_EN
    arb_port_t last_gnt_r;

    // Remember which port received the most recent grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= 1'b0;
        end else if (gnt0_s || gnt1_s) begin
            last_gnt_r <= gnt1_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    mem_arb_pick u_pick (
        .req         (req_vec_s),
        .last_gnt    (last_gnt_r),
        .winner      (pick_winner_s),
        .grant_valid (pick_valid_s)
    );
`else
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX_V = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic              hold_max_s;

    assign hold_max_s = (hold_cnt_r == HOLD_MAX_V);

    // Count port-0 grants taken while port 1 waits; saturates at MAX_HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= '0;
        end else if (gnt1_s || !bus.m1_req) begin
            hold_cnt_r <= '0;
        end else if (gnt0_s && !hold_max_s) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    mem_arb_pick u_pick (
        .req         (req_vec_s),
        .hold_max    (hold_max_s),
        .winner      (pick_winner_s),
        .grant_valid (pick_valid_s)
    );
`endif

    // Route the winning port's request fields toward the memory
    always_comb begin
        sel_addr_s  = bus.m0_addr;
        sel_wdata_s = bus.m0_wdata;
        sel_we_s    = bus.m0_we;
        if (pick_winner_s) begin
            sel_addr_s  = bus.m1_addr;
            sel_wdata_s = bus.m1_wdata;
            sel_we_s    = bus.m1_we;
        end else begin
            sel_addr_s  = bus.m0_addr;
            sel_wdata_s = bus.m0_wdata;
            sel_we_s    = bus.m0_we;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and all handshake/memory outputs; reset forces everything quiet
    always_comb begin
        state_nxt_s   = state_r;
        gnt0_s        = 1'b0;
        gnt1_s        = 1'b0;
        rvalid0_s     = 1'b0;
        rvalid1_s     = 1'b0;
        busy_s        = 1'b0;
        mem_addr_s    = '0;
        mem_wr_data_s = 32'h0;
        mem_wr_ena_s  = 1'b0;
        if (rst) begin
            state_nxt_s = ARB_IDLE;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        gnt0_s        = ~pick_winner_s;
                        gnt1_s        = pick_winner_s;
                        mem_addr_s    = sel_addr_s;
                        mem_wr_data_s = sel_wdata_s;
                        mem_wr_ena_s  = sel_we_s;
                        if (sel_we_s) begin
                            state_nxt_s = ARB_IDLE;
                        end else begin
                            state_nxt_s = ARB_WAIT;
                        end
                    end else begin
                        state_nxt_s = ARB_IDLE;
                    end
                end
                ARB_WAIT: begin
                    busy_s     = 1'b1;
                    mem_addr_s = rd_addr_r;
                    if (lat_cnt_r == 2'd0) begin
                        rvalid0_s   = ~owner_r;
                        rvalid1_s   = owner_r;
                        state_nxt_s = ARB_IDLE;
                    end else begin
                        state_nxt_s = ARB_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = ARB_IDLE;
                end
            endcase
        end
    end

    // Read bookkeeping: owner, remaining latency and the held read address
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r   <= 1'b0;
            lat_cnt_r <= 2'd0;
            rd_addr_r <= '0;
        end else if ((gnt0_s || gnt1_s) && !sel_we_s) begin
            owner_r   <= pick_winner_s;
            lat_cnt_r <= LAT_INIT;
            rd_addr_r <= sel_addr_s;
        end else if (state_r == ARB_WAIT && lat_cnt_r != 2'd0) begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
        end else begin
            lat_cnt_r <= lat_cnt_r;
        end
    end

    assign bus.m0_gnt      = gnt0_s;
    assign bus.m1_gnt      = gnt1_s;
    assign bus.m0_rvalid   = rvalid0_s;
    assign bus.m1_rvalid   = rvalid1_s;
    assign bus.busy        = busy_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wr_data = mem_wr_data_s;
    assign bus.mem_wr_ena  = mem_wr_ena_s;
    assign bus.rdata       = bus.mem_rd_data;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: two instances (READ_LATENCY 1 and 3) share the
// same stimulus; a transaction-level model checks every cycle, and directed
// literal checks pin the model to hand-computed values.
module tb_rv32_mem_arbiter;
    import mem_arb_types::*;

    localparam int MAX_HOLD = 4;
    localparam int RL_L [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        t_m0_req = 1'b0, t_m0_we = 1'b0;
    logic [31:0] t_m0_addr = 32'h0, t_m0_wdata = 32'h0;
    logic        t_m1_req = 1'b0, t_m1_we = 1'b0;
    logic [31:0] t_m1_addr = 32'h0, t_m1_wdata = 32'h0;

    logic [1:0]  o_gnt0, o_gnt1, o_rv0, o_rv1, o_busy, o_we;
    logic [31:0] o_addr [2];
    logic [31:0] o_wd   [2];
    logic [31:0] o_rdata[2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : lane
        rv32_mem_arbiter_if #(.ADDR_W(32)) bus ();

        rv32_mem_arbiter #(
            .READ_LATENCY (RL_L[g]),
            .MAX_HOLD     (MAX_HOLD),
            .ADDR_W       (32)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        logic [31:0] mem [0:63] = '{default: 32'h0};
        logic [31:0] pipe [4];

        // Memory macro: write strobe plus a read pipeline of RL stages
        always @(posedge clk) begin
            if (bus.mem_wr_ena) mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
            pipe[0] <= mem[bus.mem_addr[7:2]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end

        assign bus.mem_rd_data = pipe[RL_L[g]-1];
        assign bus.m0_req   = t_m0_req;
        assign bus.m0_we    = t_m0_we;
        assign bus.m0_addr  = t_m0_addr;
        assign bus.m0_wdata = t_m0_wdata;
        assign bus.m1_req   = t_m1_req;
        assign bus.m1_we    = t_m1_we;
        assign bus.m1_addr  = t_m1_addr;
        assign bus.m1_wdata = t_m1_wdata;

        assign o_gnt0[g]  = bus.m0_gnt;
        assign o_gnt1[g]  = bus.m1_gnt;
        assign o_rv0[g]   = bus.m0_rvalid;
        assign o_rv1[g]   = bus.m1_rvalid;
        assign o_busy[g]  = bus.busy;
        assign o_we[g]    = bus.mem_wr_ena;
        assign o_addr[g]  = bus.mem_addr;
        assign o_wd[g]    = bus.mem_wr_data;
        assign o_rdata[g] = bus.rdata;
    end

    task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d t=%0t: got %h expected %h", name, l, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          pend   [2] = '{1'b0, 1'b0};
    int          done   [2] = '{0, 0};
    bit          own    [2] = '{1'b0, 1'b0};
    logic [31:0] raddr  [2] = '{32'h0, 32'h0};
    int          streak [2] = '{0, 0};
    bit          last   [2] = '{1'b0, 1'b0};
    logic [31:0] shadow [2][64];
    int          cyc = 0;

    initial begin
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < 64; k++) shadow[l][k] = 32'h0;
    end

    // Per-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            logic e_g0, e_g1, e_v0, e_v1, e_busy, e_we, win, granted;
            logic [31:0] e_addr, e_wd;
            e_g0 = 1'b0; e_g1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
            e_busy = 1'b0; e_we = 1'b0; e_addr = 32'h0; e_wd = 32'h0;
            win = 1'b0; granted = 1'b0;
            if (rst) begin
                granted = 1'b0;
            end else if (pend[l]) begin
                e_busy = 1'b1;
                e_addr = raddr[l];
                if (cyc == done[l]) begin
                    if (own[l]) e_v1 = 1'b1; else e_v0 = 1'b1;
                end
            end else if (t_m0_req || t_m1_req) begin
                granted = 1'b1;
                if (t_m0_req && t_m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = !last[l];
`else
                    win = (streak[l] >= MAX_HOLD);
`endif
                end else begin
                    win = t_m1_req;
                end
                if (win) begin e_g1 = 1'b1; e_addr = t_m1_addr; e_wd = t_m1_wdata; e_we = t_m1_we; end
                else     begin e_g0 = 1'b1; e_addr = t_m0_addr; e_wd = t_m0_wdata; e_we = t_m0_we; end
            end
            chk("m0_gnt", l, 32'(o_gnt0[l]), 32'(e_g0));
            chk("m1_gnt", l, 32'(o_gnt1[l]), 32'(e_g1));
            chk("m0_rvalid", l, 32'(o_rv0[l]), 32'(e_v0));
            chk("m1_rvalid", l, 32'(o_rv1[l]), 32'(e_v1));
            chk("busy", l, 32'(o_busy[l]), 32'(e_busy));
            chk("mem_wr_ena", l, 32'(o_we[l]), 32'(e_we));
            chk("mem_addr", l, o_addr[l], e_addr);
            chk("mem_wr_data", l, o_wd[l], e_wd);
            if (e_v0 || e_v1) chk("rdata", l, o_rdata[l], shadow[l][raddr[l][7:2]]);

            if (rst) begin
                pend[l] = 1'b0; streak[l] = 0; last[l] = 1'b0;
            end else begin
                if (pend[l] && cyc == done[l]) begin
                    pend[l] = 1'b0;
                end else if (granted) begin
                    last[l] = win;
                    if (e_we) begin
                        shadow[l][e_addr[7:2]] = e_wd;
                    end else begin
                        pend[l] = 1'b1; done[l] = cyc + RL_L[l]; own[l] = win; raddr[l] = e_addr;
                    end
                end
                if ((granted && win) || !t_m1_req) streak[l] = 0;
                else if (granted && !win && streak[l] < MAX_HOLD) streak[l] = streak[l] + 1;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input bit q0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                          input bit q1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        t_m0_req = q0; t_m0_we = w0; t_m0_addr = a0; t_m0_wdata = d0;
        t_m1_req = q1; t_m1_we = w1; t_m1_addr = a1; t_m1_wdata = d1;
    endtask

    task automatic settle(); @(negedge clk); #1; endtask
    task automatic adv();    @(posedge clk); #1; endtask
    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin settle(); adv(); end
    endtask

    logic exp_g1;

    initial begin
        // reset with a request pending: nothing may be granted or written
        rst = 1'b1;
        set_in(1, 1, 32'h10, 32'h99, 1, 1, 32'h14, 32'h98);
        settle();
        for (int l = 0; l < 2; l++) begin
            chk("rst_gnt0", l, 32'(o_gnt0[l]), 32'd0);
            chk("rst_gnt1", l, 32'(o_gnt1[l]), 32'd0);
            chk("rst_wr_ena", l, 32'(o_we[l]), 32'd0);
            chk("rst_addr", l, o_addr[l], 32'h0);
        end
        adv();
        rst = 1'b0;

        // single write then single read of 0x10
        set_in(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        settle();
        chk("w_gnt0", 0, 32'(o_gnt0[0]), 32'd1);
        chk("w_wd", 0, o_wd[0], 32'hDEADBEEF);
        adv(); idle(1);
        set_in(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        settle();
        chk("rd_gnt0_c0", 0, 32'(o_gnt0[0]), 32'd1);
        chk("rd_addr_c0", 0, o_addr[0], 32'h10);
        adv();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("rd_busy_c1", 0, 32'(o_busy[0]), 32'd1);
        chk("rd_rvalid_c1", 0, 32'(o_rv0[0]), 32'd1);
        chk("rd_rdata_c1", 0, o_rdata[0], 32'hDEADBEEF);
        chk("rd_rvalid_c1", 1, 32'(o_rv0[1]), 32'd0);
        adv(); settle();
        chk("rd_busy_c2", 0, 32'(o_busy[0]), 32'd0);
        chk("rd_busy_c2", 1, 32'(o_busy[1]), 32'd1);
        adv(); settle();
        chk("rd_rvalid_c3", 1, 32'(o_rv0[1]), 32'd1);
        chk("rd_rdata_c3", 1, o_rdata[1], 32'hDEADBEEF);
        adv(); idle(2);

        // back-to-back writes from port 1
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 1, 1, 32'(4 * i), 32'(8'h11 * (i + 1)));
            settle();
            for (int l = 0; l < 2; l++) begin
                chk("bb_gnt1", l, 32'(o_gnt1[l]), 32'd1);
                chk("bb_wr_ena", l, 32'(o_we[l]), 32'd1);
            end
            adv();
        end
        // readback through port 0
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 32'(4 * i), 0, 0, 0, 0, 0);
            settle(); adv();
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            chk("rb_rdata", 0, o_rdata[0], 32'(8'h11 * (i + 1)));
            adv(); idle(3);
        end

        // continuous writes on both ports: starvation guard / round robin
        for (int i = 0; i < 10; i++) begin
            set_in(1, 1, 32'h20, 32'(i), 1, 1, 32'h24, 32'(256 + i));
`ifdef ARB_ROUND_ROBIN_EN
            exp_g1 = (i % 2 == 0);
`else
            exp_g1 = (i % 5 == 4);
`endif
            settle();
            chk("seq_gnt1", 0, 32'(o_gnt1[0]), 32'(exp_g1));
            chk("seq_gnt0", 0, 32'(o_gnt0[0]), 32'(!exp_g1));
            adv();
        end
        idle(1);

        // contention during a READ_LATENCY=3 read
        set_in(1, 0, 32'h8, 0, 0, 0, 0, 0);
        settle();
        chk("ct_gnt0_c0", 1, 32'(o_gnt0[1]), 32'd1);
        adv();
        set_in(0, 0, 0, 0, 1, 1, 32'hC, 32'h44);
        for (int c = 1; c <= 3; c++) begin
            settle();
            chk("ct_gnt1_wait", 1, 32'(o_gnt1[1]), 32'd0);
            chk("ct_rvalid", 1, 32'(o_rv0[1]), 32'(c == 3));
            if (c == 3) chk("ct_rdata", 1, o_rdata[1], 32'h33);
            adv();
        end
        settle();
        chk("ct_gnt1_c4", 1, 32'(o_gnt1[1]), 32'd1);
        chk("ct_busy_c4", 1, 32'(o_busy[1]), 32'd0);
        adv(); idle(2);

        // reset in the second WAIT cycle of a READ_LATENCY=3 read
        set_in(1, 0, 32'h0, 0, 0, 0, 0, 0);
        settle(); adv();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle(); adv();
        rst = 1'b1;
        settle();
        chk("mr_rvalid_rst", 1, 32'(o_rv0[1]), 32'd0);
        chk("mr_busy_rst", 1, 32'(o_busy[1]), 32'd0);
        adv();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 1, 0, 32'h4, 0);
        settle();
        chk("mr_rvalid_after", 1, 32'(o_rv0[1]), 32'd0);
        chk("mr_gnt1_after", 1, 32'(o_gnt1[1]), 32'd1);
        chk("mr_addr_after", 1, o_addr[1], 32'h4);
        adv();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("mr_busy_wait", 1, 32'(o_busy[1]), 32'd1); adv();
        settle(); adv();
        settle();
        chk("mr_rvalid1", 1, 32'(o_rv1[1]), 32'd1);
        chk("mr_rdata", 1, o_rdata[1], 32'h22);
        adv(); idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
